// File: rtl/agc_pkg.sv
// agc_pkg: ALU op codes, datapath mux encodings, mapped-register addresses, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package agc_pkg;

  localparam int W_DEF  = 16;
  localparam int AW_DEF = 12;

  // ALU operations on X (left) and Y (right)
  typedef enum logic [2:0] {
    OP_AD   = 3'd0,
    OP_SU   = 3'd1,
    OP_MASK = 3'd2,
    OP_MP0  = 3'd3,
    OP_MP1  = 3'd4,
    OP_DV0  = 3'd5,
    OP_DV1  = 3'd6,
    OP_NONE = 3'd7
  } alu_op_e;

  // Single-bit source selects
  localparam logic B_SRC_RD   = 1'b0, B_SRC_ALU  = 1'b1;
  localparam logic G_SRC_RD   = 1'b0, G_SRC_A    = 1'b1;
  localparam logic LP_SRC_A   = 1'b0, LP_SRC_ALU = 1'b1;
  localparam logic MADDR_Z    = 1'b0, MADDR_B    = 1'b1;
  localparam logic MDATA_A    = 1'b0, MDATA_G    = 1'b1;

  // Two-bit source selects
  localparam logic [1:0] A_SRC_RD = 2'd0, A_SRC_ALU = 2'd1, A_SRC_NG = 2'd2, A_SRC_G  = 2'd3;
  localparam logic [1:0] Q_SRC_A  = 2'd0, Q_SRC_G   = 2'd1, Q_SRC_Z  = 2'd2, Q_SRC_ALU = 2'd3;
  localparam logic [1:0] X_SRC_RD = 2'd0, X_SRC_Z   = 2'd1, X_SRC_A  = 2'd2, X_SRC_B  = 2'd3;
  localparam logic [1:0] Z_SRC_G  = 2'd0, Z_SRC_ALU = 2'd1, Z_SRC_B  = 2'd2, Z_SRC_Q  = 2'd3;

  // Y source select; codes 5..7 also give zero
  localparam logic [2:0] Y_SRC_ZERO = 3'd0, Y_SRC_A = 3'd1, Y_SRC_ONE = 3'd2,
                         Y_SRC_NA   = 3'd3, Y_SRC_RD = 3'd4;

  // Addresses 0..3 alias central registers instead of memory
  localparam logic [1:0] MAP_A = 2'd0, MAP_LP = 2'd1, MAP_Q = 2'd2, MAP_Z = 2'd3;

endpackage

// File: rtl/agc_alu.sv
// agc_alu: combinational ALU on X/Y (ones'-complement add/sub, mask, multiply, divide).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: x, y (operands), op (alu_op_e code), result.
module agc_alu
  import agc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   op,
  output logic [W-1:0] result
);

  logic [W:0]     w_sum;
  logic [W:0]     w_dif;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic           w_div0;

  // Carry out of the raw sum is folded back in (end-around carry). The folded add
  // can never carry again, and all-ones (-0) stays all-ones.
  assign w_sum  = {1'b0, x} + {1'b0, y};
  assign w_dif  = {1'b0, x} + {1'b0, ~y};
  assign w_prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};

  // Divide by zero saturates the quotient and passes the dividend through as remainder
  assign w_div0 = (y == '0);
  assign w_quo  = w_div0 ? '1 : x / y;
  assign w_rem  = w_div0 ? x  : x % y;

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_AD:   result = w_sum[W-1:0] + {{(W-1){1'b0}}, w_sum[W]};
      OP_SU:   result = w_dif[W-1:0] + {{(W-1){1'b0}}, w_dif[W]};
      OP_MASK: result = x & y;
      OP_MP0:  result = w_prod[W-1:0];
      OP_MP1:  result = w_prod[2*W-1:W];
      OP_DV0:  result = w_rem;
      OP_DV1:  result = w_quo;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/agc_datapath.sv
// agc_datapath: AGC register file (A, LP, G, Q, B, X, Y, Z) + ALU + memory port, driven by control pulses.
// Latency: one clk edge from pulse to visible register; memory strobe/address are combinational.
// Backpressure: none; every pulse word is applied on the next edge.
// Ports: clk/rst; *_wr write pulses; *_mux source selects; alu_op; mem_* memory port;
//        opcode/qc (B[14:12]/B[11:10]) to the sequencer; acc = A for debug.
module agc_datapath
  import agc_pkg::*;
#(
  parameter int             W        = W_DEF,
  parameter int             AW       = AW_DEF,
  parameter logic [AW-1:0]  RESET_PC = 12'h800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_wr,
  input  logic          lp_wr,
  input  logic          g_wr,
  input  logic          q_wr,
  input  logic          b_wr,
  input  logic          a_wr,
  input  logic          y_wr,
  input  logic          x_wr,
  input  logic          z_wr,
  input  logic          maddr_mux,
  input  logic          mdata_mux,
  input  logic          lp_mux,
  input  logic          g_mux,
  input  logic          b_mux,
  input  logic [1:0]    q_mux,
  input  logic [1:0]    a_mux,
  input  logic [1:0]    x_mux,
  input  logic [1:0]    z_mux,
  input  logic [2:0]    y_mux,
  input  logic [2:0]    alu_op,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  output logic          mem_we,
  input  logic [W-1:0]  mem_rdata,
  output logic [2:0]    opcode,
  output logic [1:0]    qc,
  output logic [W-1:0]  acc
);

  logic [W-1:0]  r_a, r_lp, r_g, r_q, r_b, r_x, r_y;
  logic [AW-1:0] r_z;

  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_wdata;
  logic [W-1:0]  w_z_ext;
  logic [W-1:0]  w_rd;
  logic [W-1:0]  w_alu;
  logic          w_mapped;
  logic          w_map_wr;
  logic [W-1:0]  w_a_src, w_q_src, w_x_src, w_y_src;
  logic [AW-1:0] w_z_src;

  agc_alu #(.W(W)) u_alu (
    .x      (r_x),
    .y      (r_y),
    .op     (alu_op),
    .result (w_alu)
  );

  assign w_z_ext  = {{(W-AW){1'b0}}, r_z};
  assign w_addr   = (maddr_mux == MADDR_B) ? r_b[AW-1:0] : r_z;
  assign w_wdata  = (mdata_mux == MDATA_G) ? r_g : r_a;
  assign w_mapped = (w_addr[AW-1:2] == '0);
  assign w_map_wr = mem_wr & w_mapped;

  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  // External strobe only for non-register addresses; suppressed while in reset
  assign mem_we    = mem_wr & ~w_mapped & ~rst;
  assign opcode    = r_b[14:12];
  assign qc        = r_b[11:10];
  assign acc       = r_a;

  // Read bus: low addresses alias central registers
  always_comb begin
    w_rd = mem_rdata;
    if (w_mapped) begin
      case (w_addr[1:0])
        MAP_A:   w_rd = r_a;
        MAP_LP:  w_rd = r_lp;
        MAP_Q:   w_rd = r_q;
        default: w_rd = w_z_ext;
      endcase
    end
  end

  always_comb begin
    w_a_src = w_rd;
    case (a_mux)
      A_SRC_ALU: w_a_src = w_alu;
      A_SRC_NG:  w_a_src = ~r_g;
      A_SRC_G:   w_a_src = r_g;
      default:   w_a_src = w_rd;
    endcase

    w_q_src = r_a;
    case (q_mux)
      Q_SRC_G:   w_q_src = r_g;
      Q_SRC_Z:   w_q_src = w_z_ext;
      Q_SRC_ALU: w_q_src = w_alu;
      default:   w_q_src = r_a;
    endcase

    w_x_src = w_rd;
    case (x_mux)
      X_SRC_Z: w_x_src = w_z_ext;
      X_SRC_A: w_x_src = r_a;
      X_SRC_B: w_x_src = r_b;
      default: w_x_src = w_rd;
    endcase

    w_y_src = '0;
    case (y_mux)
      Y_SRC_A:   w_y_src = r_a;
      Y_SRC_ONE: w_y_src = {{(W-1){1'b0}}, 1'b1};
      Y_SRC_NA:  w_y_src = ~r_a;
      Y_SRC_RD:  w_y_src = w_rd;
      default:   w_y_src = '0;
    endcase

    w_z_src = r_g[AW-1:0];
    case (z_mux)
      Z_SRC_ALU: w_z_src = w_alu[AW-1:0];
      Z_SRC_B:   w_z_src = r_b[AW-1:0];
      Z_SRC_Q:   w_z_src = r_q[AW-1:0];
      default:   w_z_src = r_g[AW-1:0];
    endcase
  end

  // A register's own write pulse takes priority over a mapped memory write to it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= '0;
      r_lp <= '0;
      r_g  <= '0;
      r_q  <= '0;
      r_b  <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_z  <= RESET_PC;
    end else begin
      if (a_wr)                                  r_a <= w_a_src;
      else if (w_map_wr && w_addr[1:0] == MAP_A) r_a <= w_wdata;

      if (lp_wr)                                  r_lp <= (lp_mux == LP_SRC_ALU) ? w_alu : r_a;
      else if (w_map_wr && w_addr[1:0] == MAP_LP) r_lp <= w_wdata;

      if (q_wr)                                  r_q <= w_q_src;
      else if (w_map_wr && w_addr[1:0] == MAP_Q) r_q <= w_wdata;

      if (z_wr)                                  r_z <= w_z_src;
      else if (w_map_wr && w_addr[1:0] == MAP_Z) r_z <= w_wdata[AW-1:0];

      if (g_wr) r_g <= (g_mux == G_SRC_A) ? r_a : w_rd;
      if (b_wr) r_b <= (b_mux == B_SRC_ALU) ? w_alu : w_rd;
      if (x_wr) r_x <= w_x_src;
      if (y_wr) r_y <= w_y_src;
    end
  end

endmodule
